axis_fir_sample_packer: RTL

Downstream consumer of the FIR filter AXI-Stream wrapper, in the 64 MHz domain. Takes 32-bit signed FIR accumulator results, rescales them to Q15 with round-half-up and saturation, and packs two 16-bit samples per 32-bit output word. It preserves frame boundaries on `tlast` and flushes a half-filled word at end of frame. It keeps a saturation counter for monitoring.

---
 rtl/axis_fir_sample_packer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/axis_fir_sample_packer.sv
`default_nettype none
// ============================================================================
// Module : axis_fir_sample_packer
// Rescales signed FIR results to saturated Q15 and packs two samples per
// 32-bit AXI-Stream word, flushing a half-filled word on tlast.
// Rev    : 1.0  initial release
// ============================================================================
module axis_fir_sample_packer #(
  parameter int IN_W  = 32,
  parameter int SHIFT = 15,
  parameter int ROUND = 1
) (
  input  logic            clk_64MHz,
  input  logic            resetn,
  input  logic [IN_W-1:0] S_AXIS_tdata,
  input  logic            S_AXIS_tvalid,
  input  logic            S_AXIS_tlast,
  output logic            S_AXIS_tready,
  output logic [31:0]     M_AXIS_tdata,
  output logic            M_AXIS_tvalid,
  output logic            M_AXIS_tlast,
  input  logic            M_AXIS_tready,
  output logic [15:0]     sat_count
);

  typedef enum logic [0:0] {
    ST_LOW  = 1'b0,
    ST_HIGH = 1'b1
  } state_t;

  localparam logic signed [IN_W:0] c_round =
    (ROUND != 0) ? ({{IN_W{1'b0}}, 1'b1} << (SHIFT - 1)) : '0;
  localparam logic signed [IN_W:0] c_q15_max = (IN_W + 1)'(32767);
  localparam logic signed [IN_W:0] c_q15_min = (IN_W + 1)'(-32768);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [15:0]        r_hold;
  logic               r_m_valid;
  logic [31:0]        r_m_data;
  logic               r_m_last;
  logic [15:0]        r_sat_count;

  logic               w_s_ready;
  logic               w_accept;
  logic signed [IN_W:0] w_ext;
  logic signed [IN_W:0] w_t;
  logic signed [IN_W:0] w_y;
  logic               w_sat_hi;
  logic               w_sat_lo;
  logic [15:0]        w_s16;
  logic               w_hold_en;
  logic               w_load;
  logic [31:0]        w_load_data;
  logic               w_load_last;

  // One extra bit of headroom keeps the rounding add from wrapping.
  assign w_ext    = $signed({S_AXIS_tdata[IN_W-1], S_AXIS_tdata});
  assign w_t      = w_ext + c_round;
  assign w_y      = w_t >>> SHIFT;
  assign w_sat_hi = (w_y > c_q15_max);
  assign w_sat_lo = (w_y < c_q15_min);
  assign w_s16    = w_sat_hi ? 16'h7FFF : (w_sat_lo ? 16'h8000 : w_y[15:0]);

  assign w_s_ready = resetn && (!r_m_valid || M_AXIS_tready);
  assign w_accept  = S_AXIS_tvalid && w_s_ready;

  always_ff @(posedge clk_64MHz) begin
    if (!resetn) begin
      r_state <= ST_LOW;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_hold_en   = 1'b0;
    w_load      = 1'b0;
    w_load_data = '0;
    w_load_last = 1'b0;
    if (w_accept) begin
      case (r_state)
        ST_LOW: begin
          if (S_AXIS_tlast) begin
            w_load      = 1'b1;
            w_load_data = {16'h0000, w_s16};
            w_load_last = 1'b1;
          end else begin
            w_hold_en   = 1'b1;
            w_state_nxt = ST_HIGH;
          end
        end
        ST_HIGH: begin
          w_load      = 1'b1;
          w_load_data = {w_s16, r_hold};
          w_load_last = S_AXIS_tlast;
          w_state_nxt = ST_LOW;
        end
        default: w_state_nxt = ST_LOW;
      endcase
    end
  end

  always_ff @(posedge clk_64MHz) begin
    if (!resetn) begin
      r_hold      <= '0;
      r_m_valid   <= 1'b0;
      r_m_data    <= '0;
      r_m_last    <= 1'b0;
      r_sat_count <= '0;
    end else begin
      if (w_hold_en) begin
        r_hold <= w_s16;
      end
      // A load wins over an unload so a word can be replaced in one cycle.
      if (w_load) begin
        r_m_valid <= 1'b1;
        r_m_data  <= w_load_data;
        r_m_last  <= w_load_last;
      end else if (M_AXIS_tready) begin
        r_m_valid <= 1'b0;
      end
      if (w_accept && (w_sat_hi || w_sat_lo) && (r_sat_count != 16'hFFFF)) begin
        r_sat_count <= r_sat_count + 16'd1;
      end
    end
  end

  assign S_AXIS_tready = w_s_ready;
  assign M_AXIS_tdata  = r_m_data;
  assign M_AXIS_tvalid = r_m_valid;
  assign M_AXIS_tlast  = r_m_last;
  assign sat_count     = r_sat_count;

endmodule
`default_nettype wire
